// File: rtl/addr_stream_reader.sv
// rtl/addr_stream_reader.sv - SRAM reader driven by an address generator, buffered valid/ready output (optional macro ADDR_STREAM_READER_PERF_EN adds stall_cycles)
module addr_stream_reader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  total_len,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              step,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef ADDR_STREAM_READER_PERF_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] emitted_q, emitted_d;
    logic             inflight_q, inflight_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic             pop;
    logic             push;
    logic             issue;
    logic             credit;
    logic             start_ok;
    logic [CNT_W:0]   occupancy;
    logic [LEN_W-1:0] len_m1;

    // Credit/issue decision, FIFO bookkeeping and run sequencing
    always_comb begin
        occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        credit     = occupancy < DEPTH_C;
        pop        = (count_q != '0) & out_ready;
        push       = inflight_q;
        issue      = (state_q == S_RUN) & (credit | pop);
        len_m1     = len_q - 1'b1;
        start_ok   = (state_q == S_IDLE) & start;

        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issue ? issued_q + 1'b1 : issued_q;
        emitted_d  = pop ? emitted_q + 1'b1 : emitted_q;
        inflight_d = issue;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    len_d     = total_len;
                    issued_d  = '0;
                    emitted_d = '0;
                    state_d   = (total_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (issued_q == len_m1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((count_q == '0) && !inflight_q) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and FIFO pointer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            emitted_q  <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            emitted_q  <= emitted_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Read-data storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= mem_rdata;
        end
    end

    assign step      = issue;
    assign mem_ren   = issue;
    assign mem_addr  = issue ? addr_in : '0;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign out_last  = out_valid & (len_q != '0) & (emitted_q == len_m1);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

`ifdef ADDR_STREAM_READER_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles where a buffered word waits on the consumer
    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = '0;
        end else if ((state_q != S_IDLE) && out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_addr_stream_reader.sv
// tb/tb_addr_stream_reader.sv - scoreboard testbench for addr_stream_reader
module tb_addr_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] total_len = '0;
    logic [15:0] addr_in;
    logic        step;
    logic        mem_ren;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef ADDR_STREAM_READER_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    logic        gen_load = 1'b0;
    logic [15:0] gen_base = '0;
    logic [15:0] gen_addr;

    addr_stream_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .total_len(total_len),
        .addr_in(addr_in), .step(step), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
`ifdef ADDR_STREAM_READER_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) gen_addr <= '0;
        else if (gen_load) gen_addr <= gen_base;
        else if (step) gen_addr <= gen_addr + 16'd1;
    end
    assign addr_in = gen_addr;

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem_addr + 16'h0100;
    end

    task automatic do_start(input logic [15:0] len, input logic [15:0] base);
        @(posedge clk); #1;
        start = 1'b1; total_len = len; gen_load = 1'b1; gen_base = base;
        exp_q.delete();
        for (int i = 0; i < int'(len); i++) exp_q.push_back(base + 16'h0100 + 16'(i));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({step, mem_ren, out_valid, out_last, busy, done, mem_addr} !== '0) begin
            n_bad++; $display("FAIL reset_hold: got %b, expected all zero",
                {step, mem_ren, out_valid, out_last, busy, done, mem_addr});
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({step, mem_ren, out_valid, busy, done} !== 5'b0) begin
            n_bad++; $display("FAIL reset_release: got %b, expected 00000", {step, mem_ren, out_valid, busy, done});
        end
`ifdef ADDR_STREAM_READER_PERF_EN
        n_cmp++;
        if (stall_cycles !== 32'd0) begin
            n_bad++; $display("FAIL reset_stall: got %0d, expected 0", stall_cycles);
        end
`endif
    endtask

    task automatic test_basic();
        int steps = 0, first_step = -1, last_step = -1, first_valid = -1, dones = 0;
        bit fin = 0;
        logic [15:0] e;
        out_ready = 1'b1;
        do_start(16'd8, 16'h0000);
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            @(posedge clk); #1; start = 1'b0; gen_load = 1'b0;
            @(negedge clk);
            if (step) begin steps++; if (first_step < 0) first_step = cyc; last_step = cyc; end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL basic_extra: got %h, expected no word", out_data); end
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_bad++; $display("FAIL basic_data: got %h, expected %h", out_data, e); end
                    n_cmp++;
                    if (out_last !== (exp_q.size() == 0)) begin n_bad++; $display("FAIL basic_last: got %b for %h", out_last, e); end
                end
            end
            if (done) dones++;
            else if (dones > 0 && !busy) fin = 1;
        end
        n_cmp++; if (!fin) begin n_bad++; $display("FAIL basic_timeout: got no idle, expected idle after done"); end
        n_cmp++; if (steps != 8) begin n_bad++; $display("FAIL basic_steps: got %0d, expected 8", steps); end
        n_cmp++; if (last_step - first_step != 7) begin n_bad++; $display("FAIL basic_consec: got span %0d, expected 7", last_step - first_step); end
        n_cmp++; if (first_valid - first_step != 2) begin n_bad++; $display("FAIL basic_latency: got %0d, expected 2", first_valid - first_step); end
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL basic_done: got %0d pulses, expected 1", dones); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL basic_left: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int steps = 0, stall_steps = 0, dones = 0;
        bit fin = 0;
        logic [15:0] e;
        out_ready = 1'b0;
        do_start(16'd10, 16'h0020);
        for (int cyc = 0; cyc < 150 && !fin; cyc++) begin
            @(posedge clk); #1; start = 1'b0; gen_load = 1'b0; out_ready = (cyc >= 20);
            @(negedge clk);
            if (step) begin steps++; if (cyc < 20) stall_steps++; end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_extra: got %h, expected no word", out_data); end
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_bad++; $display("FAIL bp_data: got %h, expected %h", out_data, e); end
                    n_cmp++;
                    if (out_last !== (exp_q.size() == 0)) begin n_bad++; $display("FAIL bp_last: got %b for %h", out_last, e); end
                end
            end
            if (done) dones++;
            else if (dones > 0 && !busy) fin = 1;
        end
        n_cmp++; if (!fin) begin n_bad++; $display("FAIL bp_timeout: got no idle, expected idle after done"); end
        n_cmp++; if (stall_steps != 4) begin n_bad++; $display("FAIL bp_credit: got %0d issues while stalled, expected 4", stall_steps); end
        n_cmp++; if (steps != 10) begin n_bad++; $display("FAIL bp_steps: got %0d, expected 10", steps); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_left: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_toggle();
        int steps = 0, pops = 0, dones = 0;
        bit fin = 0;
        logic [15:0] e;
        do_start(16'd6, 16'h0040);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            @(posedge clk); #1; start = 1'b0; gen_load = 1'b0; out_ready = (cyc % 2 == 0);
            @(negedge clk);
            if (step) steps++;
            if (out_valid && out_ready) begin
                pops++;
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL tog_extra: got %h, expected no word", out_data); end
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_bad++; $display("FAIL tog_data: got %h, expected %h", out_data, e); end
                end
            end
            if (done) dones++;
            else if (dones > 0 && !busy) fin = 1;
        end
        n_cmp++; if (!fin) begin n_bad++; $display("FAIL tog_timeout: got no idle, expected idle after done"); end
        n_cmp++; if (steps != 6) begin n_bad++; $display("FAIL tog_steps: got %0d, expected 6", steps); end
        n_cmp++; if (pops != 6) begin n_bad++; $display("FAIL tog_pops: got %0d, expected 6", pops); end
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL tog_done: got %0d pulses, expected 1", dones); end
    endtask

    task automatic test_zero_len();
        int issues = 0, valids = 0, dones = 0, done_cyc = -1;
        out_ready = 1'b1;
        do_start(16'd0, 16'h0050);
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk); #1; start = 1'b0; gen_load = 1'b0;
            @(negedge clk);
            if (step || mem_ren) issues++;
            if (out_valid) valids++;
            if (done) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
        end
        n_cmp++; if (issues != 0) begin n_bad++; $display("FAIL zero_issue: got %0d, expected 0", issues); end
        n_cmp++; if (valids != 0) begin n_bad++; $display("FAIL zero_valid: got %0d, expected 0", valids); end
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL zero_done: got %0d pulses, expected 1", dones); end
        n_cmp++; if (done_cyc < 0 || done_cyc > 1) begin n_bad++; $display("FAIL zero_done_time: got cycle %0d, expected 0..1", done_cyc); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int pops = 0, steps = 0, dones = 0;
        bit fin = 0;
        logic [15:0] e;
        out_ready = 1'b1;
        do_start(16'd8, 16'h0060);
        for (int cyc = 0; cyc < 40 && pops < 3; cyc++) begin
            @(posedge clk); #1; start = 1'b0; gen_load = 1'b0;
            @(negedge clk);
            if (out_valid && out_ready) pops++;
        end
        @(posedge clk); #1; rst_n = 1'b0; #1;
        n_cmp++;
        if ({step, mem_ren, out_valid, out_last, busy, done, mem_addr} !== '0) begin
            n_bad++; $display("FAIL midrst_outputs: got %b, expected all zero",
                {step, mem_ren, out_valid, out_last, busy, done, mem_addr});
        end
        @(posedge clk); #1; rst_n = 1'b1;
        do_start(16'd4, 16'h0080);
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            @(posedge clk); #1; start = 1'b0; gen_load = 1'b0;
            if (cyc == 2) begin start = 1'b1; total_len = 16'd9; end
            @(negedge clk);
            if (step) steps++;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL rerun_extra: got %h, expected no word", out_data); end
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_bad++; $display("FAIL rerun_data: got %h, expected %h", out_data, e); end
                end
            end
            if (done) dones++;
            else if (dones > 0 && !busy) fin = 1;
        end
        n_cmp++; if (!fin) begin n_bad++; $display("FAIL rerun_timeout: got no idle, expected idle after done"); end
        n_cmp++; if (steps != 4) begin n_bad++; $display("FAIL rerun_steps: got %0d, expected 4", steps); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rerun_left: got %0d left, expected 0", exp_q.size()); end
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL rerun_done: got %0d pulses, expected 1", dones); end
    endtask

`ifdef ADDR_STREAM_READER_PERF_EN
    task automatic test_perf();
        int sv = 0, dones = 0;
        bit fin = 0;
        out_ready = 1'b0;
        do_start(16'd4, 16'h00a0);
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            @(posedge clk); #1; start = 1'b0; gen_load = 1'b0; out_ready = (sv >= 5);
            @(negedge clk);
            if (out_valid && !out_ready) sv++;
            if (out_valid && out_ready) void'(exp_q.pop_front());
            if (done) dones++;
            else if (dones > 0 && !busy) fin = 1;
        end
        n_cmp++; if (!fin) begin n_bad++; $display("FAIL perf_timeout: got no idle, expected idle after done"); end
        n_cmp++; if (stall_cycles !== 32'd5) begin n_bad++; $display("FAIL perf_count: got %0d, expected 5", stall_cycles); end
        out_ready = 1'b1;
        do_start(16'd4, 16'h00b0);
        @(posedge clk); #1; start = 1'b0; gen_load = 1'b0;
        @(negedge clk);
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL perf_clear: got %0d, expected 0", stall_cycles); end
        repeat (12) @(posedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_toggle();
        test_zero_len();
        test_reset_mid_run();
`ifdef ADDR_STREAM_READER_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
